// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      IDLE    = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/md_sequencer.sv
// Busy FSM that holds a multi-cycle multiply/divide op in E for MD_LATENCY cycles.
module md_sequencer
   import hazard_pkg::*;
#(
   parameter int unsigned MD_LATENCY = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_md_start,
   output logic o_md_stall,
   output logic o_md_busy
);

   localparam logic [3:0] CNT_LOAD = 4'(MD_LATENCY - 2);

   md_state_t  r_state;
   md_state_t  w_state_nx;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nx;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   // The final cycle in MD_BUSY releases the stall; a new start seen then belongs to the same op.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      o_md_stall = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_md_start) begin
               w_state_nx = MD_BUSY;
               w_cnt_nx   = CNT_LOAD;
               o_md_stall = 1'b1;
            end
         end
         MD_BUSY: begin
            if (r_cnt != 4'd0) begin
               w_cnt_nx   = r_cnt - 4'd1;
               o_md_stall = 1'b1;
            end else begin
               w_state_nx = IDLE;
            end
         end
      endcase
   end

   assign o_md_busy = (r_state == MD_BUSY);

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline hazard controller: stall/flush priority, E-stage forwarding selects,
// multi-cycle op sequencing and a stall-cycle performance counter.
module hazard_scheduler
   import hazard_pkg::*;
#(
   parameter int unsigned MD_LATENCY = 4,
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned CNT_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] RsD,
   input  logic [REG_AW-1:0] RtD,
   input  logic [REG_AW-1:0] RsE,
   input  logic [REG_AW-1:0] RtE,
   input  logic [REG_AW-1:0] WriteRegE,
   input  logic [REG_AW-1:0] WriteRegM,
   input  logic [REG_AW-1:0] WriteRegW,
   input  logic              RegWriteE,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic              MemtoRegE,
   input  logic              PCSrcE,
   input  logic              MdStartE,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushM,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              MdBusy,
   output logic [CNT_W-1:0]  StallCycles
);

   localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

   logic       w_md_stall;
   logic       w_lw_stall;
   fwd_sel_t   w_fwd_a;
   fwd_sel_t   w_fwd_b;
   logic [CNT_W-1:0] r_stall_cycles;

   md_sequencer #(
      .MD_LATENCY (MD_LATENCY)
   ) u_md_sequencer (
      .clk        (clk),
      .reset      (reset),
      .i_md_start (MdStartE),
      .o_md_stall (w_md_stall),
      .o_md_busy  (MdBusy)
   );

   function automatic fwd_sel_t fwd_select(input logic [REG_AW-1:0] src,
                                           input logic              we_m,
                                           input logic [REG_AW-1:0] wr_m,
                                           input logic              we_w,
                                           input logic [REG_AW-1:0] wr_w);
      if (we_m && (wr_m != RZ) && (wr_m == src)) return FWD_M;
      if (we_w && (wr_w != RZ) && (wr_w == src)) return FWD_W;
      return FWD_RF;
   endfunction

   assign w_fwd_a = fwd_select(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
   assign w_fwd_b = fwd_select(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);

   assign w_lw_stall = MemtoRegE && RegWriteE && (WriteRegE != RZ) &&
                       ((RsD == WriteRegE) || (RtD == WriteRegE));

   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushM    = 1'b0;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      if (reset) begin
         ForwardAE = w_fwd_a;
         ForwardBE = w_fwd_b;
         // A taken branch outranks load-use but never a multi-cycle op still occupying E.
         if (w_md_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
         end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (w_lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_stall_cycles <= '0;
      end else if (StallF) begin
         r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
   end

   assign StallCycles = r_stall_cycles;

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Central hazard controller for the 5-stage pipeline.
- Drives stall and flush controls for the F, D, E and M pipeline registers. FlushE feeds the clr input of the decode-to-execute register.
- Generates the E-stage operand forwarding selects.
- Sequences multi-cycle execute operations (multiply/divide) through a small busy FSM.
- Counts stall cycles for performance monitoring.

Parameters:
MD_LATENCY, 4, total cycles a multi-cycle op occupies E; legal range 2..16
REG_AW, 5, register-address width
CNT_W, 32, stall-cycle counter width

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous, active-low reset; sampled on rising clk
RsD, RtD  in  REG_AW  source registers of the instruction in D
RsE, RtE  in  REG_AW  source registers of the instruction in E
WriteRegE, WriteRegM, WriteRegW  in  REG_AW  destination register per stage
RegWriteE, RegWriteM, RegWriteW  in  1  register-write enable per stage
MemtoRegE  in  1  instruction in E is a load
PCSrcE  in  1  branch in E resolved taken
MdStartE  in  1  instruction in E is a multi-cycle op
StallF, StallD, StallE  out  1  hold the corresponding pipeline register
FlushD, FlushE, FlushM  out  1  clear the corresponding pipeline register (bubble)
ForwardAE, ForwardBE  out  2  00 = register file, 01 = W result, 10 = M ALU result
MdBusy  out  1  FSM in MD_BUSY
StallCycles  out  CNT_W  count of cycles with StallF = 1

Behaviour:
- Reset (reset == 0 at a clock edge):
  - state <= IDLE, cnt <= 0, StallCycles <= 0.
  - While reset is low, all stall/flush/forward outputs are forced to 0.
  - Reset mid-MD_BUSY aborts the operation; the cycle after reset releases shows IDLE.
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM & WriteRegM != 0 & WriteRegM == RsE.
  - Otherwise 01 if RegWriteW & WriteRegW != 0 & WriteRegW == RsE.
  - Otherwise 00.
  - ForwardBE is identical, using RtE.
  - M has priority over W. Register 0 is never forwarded.
- Load-use: lwstall = MemtoRegE & RegWriteE & WriteRegE != 0 & (RsD == WriteRegE | RtD == WriteRegE).
- Multi-cycle FSM, states IDLE and MD_BUSY, cnt width 4:
  - IDLE & MdStartE: next state MD_BUSY, cnt <= MD_LATENCY-2; mdstall = 1 this cycle.
  - MD_BUSY & cnt != 0: cnt <= cnt-1; mdstall = 1.
  - MD_BUSY & cnt == 0: mdstall = 0; next state IDLE. MdStartE is ignored in this cycle (same op is leaving E).
  - Net effect: op held in E for exactly MD_LATENCY cycles, with MD_LATENCY-1 stall cycles.
  - MdBusy = (state == MD_BUSY).
- Output priority, highest first; exactly one case applies:
  1. mdstall: StallF = StallD = StallE = 1, FlushM = 1; all other controls 0.
  2. PCSrcE: FlushD = FlushE = 1; all stalls 0 (redirect wins, lwstall ignored).
  3. lwstall: StallF = StallD = 1, FlushE = 1.
  4. Otherwise all stall/flush outputs are 0.
- Forwarding selects are valid in every case, including during mdstall.
- StallCycles: increments by 1 each cycle StallF = 1 and reset == 1; wraps to 0 at all-ones.
- Latency: all control outputs are combinational from inputs and current state, same cycle. Only state, cnt and StallCycles are registered.

Decomposition:
- Package hazard_pkg holds:
  - typedef fwd_sel_t (2-bit enum: FWD_RF = 00, FWD_W = 01, FWD_M = 10)
  - typedef md_state_t (IDLE, MD_BUSY)
  - constant REG_ZERO
- One sub-module: md_sequencer. It contains the FSM, cnt and the mdstall/MdBusy outputs, parameterised by MD_LATENCY.
- Forwarding and priority logic stay in the top level.

Test Plan:
1. RegWriteM = 1, WriteRegM = 5, RsE = 5; RegWriteW = 1, WriteRegW = 5 -> ForwardAE = 10. Then WriteRegM = 0, RsE = 0 -> ForwardAE = 00.
2. MemtoRegE = RegWriteE = 1, WriteRegE = 8, RtD = 8 -> StallF = StallD = FlushE = 1 for one cycle; StallCycles +1. With WriteRegE = 0 -> no stall.
3. Load-use condition plus PCSrcE = 1 in the same cycle -> FlushD = FlushE = 1, StallF = StallD = 0, StallCycles unchanged.
4. MdStartE held high 4 cycles, MD_LATENCY = 4 -> StallF/StallD/StallE/FlushM = 1 in cycles 0-2, 0 in cycle 3; MdBusy = 1 in cycles 1-3; StallCycles = 3.
5. reset = 0 asserted in cycle 2 of an MD_BUSY op -> next cycle IDLE, MdBusy = 0, StallCycles = 0, all controls 0.
6. StallCycles preloaded to all-ones via a forced stall run, then one more stall cycle -> wraps to 0.
